// File: rtl/real_to_bin.sv
// Sequential speed quantizer: signed real speed (mm/s) -> {direction, magnitude[1:0]}.
// Fixed-latency compare sequence; exact inverse encoder of bin_to_real.
module real_to_bin #(
  parameter int WIDTH  = 32,
  parameter int LEVEL1 = 100,
  parameter int LEVEL2 = 200,
  parameter int LEVEL3 = 300
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] real_speed,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       bin_speed,
  output logic             direction,
  output logic             out_valid,
  input  logic             out_ready
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds data stable while valid is high and unaccepted.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    CMP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [WIDTH:0] LVL1 = (WIDTH+1)'(LEVEL1);
  localparam logic [WIDTH:0] LVL2 = (WIDTH+1)'(LEVEL2);
  localparam logic [WIDTH:0] LVL3 = (WIDTH+1)'(LEVEL3);

  state_t           state, state_next;
  logic [WIDTH-1:0] speed_q;
  logic             sign_q;
  logic [WIDTH:0]   abs_q;
  logic [1:0]       step_q;
  logic [1:0]       mag_q;
  logic [2:0]       bin_q;

  logic [WIDTH:0]   speed_ext;
  logic [WIDTH:0]   level_sel;
  logic [1:0]       mag_cand;
  logic [1:0]       mag_next;
  logic             hit;

  // One extra bit so that negating the most negative value cannot overflow.
  assign speed_ext = {speed_q[WIDTH-1], speed_q};

  always_comb begin
    level_sel = LVL1;
    case (step_q)
      2'd0:    level_sel = LVL3;
      2'd1:    level_sel = LVL2;
      default: level_sel = LVL1;
    endcase
  end

  // Steps run from the highest level down; the first level reached fixes the code.
  assign hit      = (abs_q >= level_sel);
  assign mag_cand = 2'd3 - step_q;
  assign mag_next = ((mag_q == 2'd0) && hit) ? mag_cand : mag_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = ABS;
      ABS:  state_next = CMP;
      CMP:  if (step_q == 2'd2) state_next = HOLD;
      HOLD: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      speed_q <= '0;
      sign_q  <= 1'b0;
      abs_q   <= '0;
      step_q  <= 2'd0;
      mag_q   <= 2'd0;
      bin_q   <= 3'b000;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (in_valid) speed_q <= real_speed;
        ABS: begin
          sign_q <= speed_q[WIDTH-1];
          abs_q  <= speed_q[WIDTH-1] ? (-speed_ext) : speed_ext;
          step_q <= 2'd0;
          mag_q  <= 2'd0;
        end
        CMP: begin
          mag_q  <= mag_next;
          step_q <= step_q + 2'd1;
          // Magnitude 0 never carries a direction: no negative-zero code.
          if (step_q == 2'd2)
            bin_q <= {sign_q & (mag_next != 2'd0), mag_next};
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign bin_speed = bin_q;
  assign direction = bin_q[2];

endmodule

// File: tb/tb_real_to_bin.sv
// Directed bench for real_to_bin: latency, level boundaries, extremes,
// backpressure and mid-conversion reset.
module tb_real_to_bin;

  logic        clk;
  logic        reset;
  logic [31:0] real_speed;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  bin_speed;
  logic        direction;
  logic        out_valid;
  logic        out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  real_to_bin #(.WIDTH(32), .LEVEL1(100), .LEVEL2(200), .LEVEL3(300)) dut (
    .clk        (clk),
    .reset      (reset),
    .real_speed (real_speed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bin_speed  (bin_speed),
    .direction  (direction),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full conversion with out_ready held high; checks latency, code and turnaround.
  task automatic conv(input logic [31:0] spd, input logic [2:0] exp, input string tag);
    int cycles;
    real_speed = spd;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    tick();
    in_valid = 1'b0;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check({tag, "_latency"}, cycles, 4);
    check({tag, "_code"}, {29'd0, bin_speed}, {29'd0, exp});
    check({tag, "_dir"}, {31'd0, direction}, {31'd0, exp[2]});
    tick();
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [31:0] pos_v[7];
  logic [2:0]  pos_c[7];
  logic [31:0] neg_v[4];
  logic [2:0]  neg_c[4];

  initial begin
    int cycles;
    int seen;
    pos_v = '{32'd99, 32'd100, 32'd199, 32'd200, 32'd299, 32'd300, 32'd500};
    pos_c = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b011, 3'b011};
    neg_v = '{-32'sd100, -32'sd250, -32'sd300, -32'sd99};
    neg_c = '{3'b101, 3'b110, 3'b111, 3'b000};

    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    real_speed = '0;
    tick();
    tick();
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bin",       {29'd0, bin_speed}, 32'd0);
    check("rst_dir",       {31'd0, direction}, 32'd0);
    reset = 1'b0;
    tick();

    // Zero speed, checking in_ready and out_valid every cycle of the conversion.
    real_speed = 32'd0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check("zero_busy_in_ready", {31'd0, in_ready},  32'd0);
      check("zero_busy_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    check("zero_in_ready_n4", {31'd0, in_ready},  32'd0);
    check("zero_out_valid_n4", {31'd0, out_valid}, 32'd0);
    tick();
    check("zero_out_valid", {31'd0, out_valid}, 32'd1);
    check("zero_code",      {29'd0, bin_speed}, 32'd0);
    check("zero_in_ready_hold", {31'd0, in_ready}, 32'd0);
    tick();
    check("zero_handshake_in_ready", {31'd0, in_ready},  32'd1);
    check("zero_handshake_out_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 7; i++) conv(pos_v[i], pos_c[i], $sformatf("pos%0d", i));
    for (int i = 0; i < 4; i++) conv(neg_v[i], neg_c[i], $sformatf("neg%0d", i));
    conv(32'h8000_0000, 3'b111, "min_int");
    conv(32'h7fff_ffff, 3'b011, "max_int");

    // Backpressure with a stray in_valid pulse while the result is held.
    real_speed = -32'sd250;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    tick();
    in_valid = 1'b0;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check("bp_latency", cycles, 4);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        real_speed = 32'd500;
        in_valid   = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check("bp_code",      {29'd0, bin_speed}, {29'd0, 3'b110});
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
    check("bp_release_code_kept", {29'd0, bin_speed}, {29'd0, 3'b110});
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    check("bp_pulse_ignored", seen, 0);

    // Reset during CMP step 1 of a +300 conversion.
    real_speed = 32'd300;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_code",      {29'd0, bin_speed}, 32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0 || bin_speed !== 3'b000) seen++;
    end
    check("midrst_no_result", seen, 0);

    conv(32'd150, 3'b001, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/real_to_bin.md
# real_to_bin

Sequential speed quantizer. It converts a signed WIDTH-bit real wheel speed (mm/s) into the 3-bit binary speed code `{direction, magnitude[1:0]}` used on the drive path, and it is the exact inverse encoder of `bin_to_real`. It sits between the navigation/sensor-feedback logic and any block that consumes `bin_speed` codes, such as logging or the command link. Transfers use valid/ready handshakes on both sides, and conversion is a fixed-latency multi-cycle compare sequence.

## Interface
Parameters:
- `WIDTH`, 32: width of `real_speed`, two's-complement.
- `LEVEL1`, 100: minimum |speed| for magnitude code 1 (unsigned).
- `LEVEL2`, 200: minimum |speed| for magnitude code 2. Must satisfy LEVEL1 < LEVEL2.
- `LEVEL3`, 300: minimum |speed| for magnitude code 3. Must satisfy LEVEL2 < LEVEL3 < 2^(WIDTH-1).

Ports:
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `real_speed`, input, WIDTH: signed speed, sampled on the input handshake.
- `in_valid`, input, 1: `real_speed` is valid.
- `in_ready`, output, 1: block can accept an input (high only in IDLE).
- `bin_speed`, output, 3: result code. `[2]` is direction, `[1:0]` is magnitude.
- `direction`, output, 1: equals `bin_speed[2]`; 1 means reverse (negative).
- `out_valid`, output, 1: `bin_speed` holds a new result.
- `out_ready`, input, 1: consumer accepts the result.

## Operation
- FSM states: IDLE, ABS, CMP (3 steps, 2-bit step counter), HOLD.
- IDLE: `in_ready`=1. If `in_valid` is high at a rising edge, capture `real_speed` and go to ABS.
- ABS: register the sign bit and compute |speed| in WIDTH+1 bits. This makes -2^(WIDTH-1) produce a correct positive magnitude, with no overflow.
- CMP step 0: compare |speed| against LEVEL3. Step 1: compare against LEVEL2. Step 2: compare against LEVEL1.
  - Magnitude is the largest k for which |speed| >= LEVELk, else 0.
  - All three steps always execute; there is no early exit, so latency is fixed.
- Results saturate at magnitude 3; any |speed| >= LEVEL3 gives 3.
- Direction = sign bit, except that magnitude 0 forces direction to 0. There is no "negative zero" code (3'b100 is never produced).
- After step 2, load `bin_speed` and go to HOLD.
- HOLD: `out_valid`=1 and `bin_speed` is stable. On an edge with `out_ready`=1, return to IDLE.
- `bin_speed` and `direction` keep the last result after the handshake, until the next result is loaded.
- `in_valid` is ignored outside IDLE; no input is queued.

## Timing
- Reset value of every output after a reset edge: `in_ready`=1, `out_valid`=0, `bin_speed`=3'b000, `direction`=0. The state is IDLE.
- Reset mid-operation, in any state, aborts the conversion. The pending result is discarded and never presented.
- Latency: input accepted at edge N. ABS at N+1, CMP steps at N+2, N+3, N+4. `out_valid` is high from just after edge N+4.
- Earliest output handshake is at edge N+5 (if `out_ready` is already high). `in_ready` rises after N+5, giving 6 cycles per conversion minimum.
- `out_ready` stuck low: the block stays in HOLD indefinitely with outputs stable and `in_ready`=0.
- `out_ready` high with no `out_valid` has no effect.
- Boundaries are inclusive:
  - |speed| = LEVELk gives code k.
  - |speed| = LEVELk - 1 gives k-1.

## Test plan
- Reset, then `real_speed`=0 accepted: `bin_speed`=3'b000 and `out_valid` high 4 edges after acceptance. `in_ready` is low for the whole conversion.
- Sweep +99, +100, +199, +200, +299, +300, +500 with `out_ready` held high. Required codes: 000, 001, 001, 010, 010, 011, 011. Each conversion takes 6 cycles.
- Sweep -100, -250, -300, -99. Required codes: 101, 110, 111, 000 (direction forced 0 for -99).
- Extremes -2^31 and 2^31-1: both give magnitude 3, with codes 111 and 011 respectively. No wrap to 0.
- Backpressure: hold `out_ready` low for 10 cycles after `out_valid` rises.
  - `bin_speed` must stay stable and `in_ready` must stay 0.
  - An `in_valid` pulse applied meanwhile must be ignored.
  - Release `out_ready`: one handshake occurs, then `in_ready`=1.
- Reset asserted during CMP step 1 of a +300 conversion: next cycle `out_valid`=0, `bin_speed`=000, `in_ready`=1. The +300 result never appears.
